// File: rtl/pipe_controller_if.sv
// Control-bus bundle for pipe_controller: Decode-stage instruction fields, hazard
// requests, and the per-stage control outputs, with modports for driver and controller.
interface pipe_controller_if #(
   parameter int ALUCTRL_W = 3
);
   logic [5:0]           opD;
   logic [5:0]           functD;
   logic                 equalD;
   logic                 stallE;
   logic                 stallM;
   logic                 flushE;
   logic                 flushM;

   logic                 branchD;
   logic                 jumpD;
   logic                 jrD;
   logic                 pcsrcD;
   logic                 regwriteD;
   logic                 illegalD;
   logic                 divstallD;

   logic                 alusrcE;
   logic                 regdstE;
   logic                 memtoregE;
   logic                 regwriteE;
   logic                 divE;
   logic [ALUCTRL_W-1:0] alucontrolE;

   logic                 memwriteM;
   logic                 memtoregM;
   logic                 regwriteM;
   logic                 memtoregW;
   logic                 regwriteW;
   logic                 divbusy;

   modport slave (
      input  opD, functD, equalD, stallE, stallM, flushE, flushM,
      output branchD, jumpD, jrD, pcsrcD, regwriteD, illegalD, divstallD,
      output alusrcE, regdstE, memtoregE, regwriteE, divE, alucontrolE,
      output memwriteM, memtoregM, regwriteM, memtoregW, regwriteW, divbusy
   );

   modport master (
      output opD, functD, equalD, stallE, stallM, flushE, flushM,
      input  branchD, jumpD, jrD, pcsrcD, regwriteD, illegalD, divstallD,
      input  alusrcE, regdstE, memtoregE, regwriteE, divE, alucontrolE,
      input  memwriteM, memtoregM, regwriteM, memtoregW, regwriteW, divbusy
   );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined MIPS-style main controller: combinational Decode, E/M/W control registers
// with stall/flush handling, and an occupancy counter for the multicycle divider.
module pipe_controller #(
   parameter int ALUCTRL_W  = 3,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_controller_if.slave  bus
);
   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_OR   = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_SUB  = 3'd6;
   localparam logic [2:0] ALU_SLT  = 3'd7;

   typedef struct packed {
      logic                 alusrc;
      logic                 regdst;
      logic                 memtoreg;
      logic                 memwrite;
      logic                 regwrite;
      logic                 div;
      logic [ALUCTRL_W-1:0] alu;
   } e_bundle_t;

   typedef struct packed {
      logic memwrite;
      logic memtoreg;
      logic regwrite;
   } m_bundle_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } w_bundle_t;

   logic       w_alusrc;
   logic       w_regdst;
   logic       w_memtoreg;
   logic       w_memwrite;
   logic       w_regwrite;
   logic       w_branch;
   logic       w_jump;
   logic       w_jr;
   logic       w_div;
   logic       w_mfhi;
   logic       w_mflo;
   logic       w_illegal;
   logic [2:0] w_alu;

   logic       w_pcsrc;
   logic       w_divstall;
   logic       w_div_start;
   e_bundle_t  w_d_bundle;

   e_bundle_t       r_e;
   m_bundle_t       r_m;
   w_bundle_t       r_w;
   logic [CNT_W-1:0] r_div_cnt;
   logic            r_divbusy;

   // Main decoder: opcode selects the class, funct refines R-type
   always_comb begin
      w_alusrc   = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_jr       = 1'b0;
      w_div      = 1'b0;
      w_mfhi     = 1'b0;
      w_mflo     = 1'b0;
      w_illegal  = 1'b0;
      w_alu      = ALU_AND;
      case (bus.opD)
         OP_RTYPE: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            case (bus.functD)
               FN_ADD:  w_alu = ALU_ADD;
               FN_SUB:  w_alu = ALU_SUB;
               FN_AND:  w_alu = ALU_AND;
               FN_OR:   w_alu = ALU_OR;
               FN_SLT:  w_alu = ALU_SLT;
               FN_JR: begin
                  w_jr       = 1'b1;
                  w_regwrite = 1'b0;
               end
               FN_DIV: begin
                  w_div      = 1'b1;
                  w_regwrite = 1'b0;
               end
               FN_MFHI: w_mfhi = 1'b1;
               FN_MFLO: w_mflo = 1'b1;
               default: begin
                  w_regwrite = 1'b0;
                  w_illegal  = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            w_alusrc   = 1'b1;
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_alu      = ALU_ADD;
         end
         OP_SW: begin
            w_alusrc   = 1'b1;
            w_memwrite = 1'b1;
            w_alu      = ALU_ADD;
         end
         OP_BEQ, OP_BNE: begin
            w_branch = 1'b1;
            w_alu    = ALU_SUB;
         end
         OP_ADDI: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
            w_alu      = ALU_ADD;
         end
         OP_ANDI: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
            w_alu      = ALU_AND;
         end
         OP_ORI: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
            w_alu      = ALU_OR;
         end
         OP_J:    w_jump    = 1'b1;
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_pcsrc     = w_branch & ((bus.opD == OP_BEQ) ? bus.equalD : ~bus.equalD);
   assign w_divstall  = r_divbusy & (w_div | w_mfhi | w_mflo);
   assign w_div_start = w_div & ~r_divbusy & ~bus.flushE & ~bus.stallE;

   // An instruction held in Decode by the divider must not also advance, so E gets a bubble
   always_comb begin
      w_d_bundle = '0;
      if (w_divstall) begin
         w_d_bundle = '0;
      end else begin
         w_d_bundle.alusrc   = w_alusrc;
         w_d_bundle.regdst   = w_regdst;
         w_d_bundle.memtoreg = w_memtoreg;
         w_d_bundle.memwrite = w_memwrite;
         w_d_bundle.regwrite = w_regwrite;
         w_d_bundle.div      = w_div;
         w_d_bundle.alu      = ALUCTRL_W'(w_alu);
      end
   end

   // Execute-stage control register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e <= '0;
      end else if (bus.flushE) begin
         r_e <= '0;
      end else if (bus.stallE) begin
         r_e <= r_e;
      end else begin
         r_e <= w_d_bundle;
      end
   end

   // Memory-stage control register; a stalled E feeds a bubble forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m <= '0;
      end else if (bus.flushM) begin
         r_m <= '0;
      end else if (bus.stallM) begin
         r_m <= r_m;
      end else if (bus.stallE) begin
         r_m <= '0;
      end else begin
         r_m <= '{memwrite: r_e.memwrite, memtoreg: r_e.memtoreg, regwrite: r_e.regwrite};
      end
   end

   // Writeback-stage control register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w <= '0;
      end else begin
         r_w <= '{memtoreg: r_m.memtoreg, regwrite: r_m.regwrite};
      end
   end

   // Divider occupancy: busy for exactly DIV_CYCLES cycles, ignoring pipeline hazards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= CNT_ZERO;
         r_divbusy <= 1'b0;
      end else if (w_div_start) begin
         r_div_cnt <= CNT_LOAD;
         r_divbusy <= 1'b1;
      end else if (r_divbusy) begin
         if (r_div_cnt == CNT_ZERO) begin
            r_divbusy <= 1'b0;
         end else begin
            r_div_cnt <= r_div_cnt - CNT_ONE;
         end
      end else begin
         r_div_cnt <= r_div_cnt;
         r_divbusy <= r_divbusy;
      end
   end

   assign bus.branchD     = w_branch;
   assign bus.jumpD       = w_jump;
   assign bus.jrD         = w_jr;
   assign bus.pcsrcD      = w_pcsrc;
   assign bus.regwriteD   = w_regwrite;
   assign bus.illegalD    = w_illegal;
   assign bus.divstallD   = w_divstall;

   assign bus.alusrcE     = r_e.alusrc;
   assign bus.regdstE     = r_e.regdst;
   assign bus.memtoregE   = r_e.memtoreg;
   assign bus.regwriteE   = r_e.regwrite;
   assign bus.divE        = r_e.div;
   assign bus.alucontrolE = r_e.alu;

   assign bus.memwriteM   = r_m.memwrite;
   assign bus.memtoregM   = r_m.memtoreg;
   assign bus.regwriteM   = r_m.regwrite;
   assign bus.memtoregW   = r_w.memtoreg;
   assign bus.regwriteW   = r_w.regwrite;
   assign bus.divbusy     = r_divbusy;
endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, meaning ALU control width (min 3); codes zero-extended to this width.
REQ-002 Parameter DIV_CYCLES, default 32, meaning divider occupancy in cycles (min 2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 opD, functD  in  6 each  instruction opcode/funct in Decode.
REQ-007 equalD  in  1  register-compare result in Decode.
REQ-008 stallE, stallM  in  1 each  hold request for E / M pipeline registers.
REQ-009 flushE, flushM  in  1 each  clear request for E / M pipeline registers.
REQ-010 branchD, jumpD, jrD, pcsrcD, regwriteD, illegalD, divstallD  out  1 each  Decode-stage combinational controls.
REQ-011 alusrcE, regdstE, memtoregE, regwriteE  out  1 each; alucontrolE  out  ALUCTRL_W.
REQ-012 memwriteM, memtoregM, regwriteM  out  1 each; memtoregW, regwriteW  out  1 each.
REQ-013 divbusy  out  1  multicycle divider occupied.

Function
REQ-014 Decode SHALL be: op 000000 R-type (regdst, regwrite); 100011 lw (alusrc, memtoreg, regwrite, add); 101011 sw (alusrc, memwrite, add); 000100 beq, 000101 bne (branch, sub); 001000 addi (alusrc, regwrite, add); 001100 andi, 001101 ori (alusrc, regwrite, and/or); 000010 j (jump); any other op -> all controls 0, illegalD=1.
REQ-015 R-type funct SHALL map: 100000 add=2, 100010 sub=6, 100100 and=0, 100101 or=1, 101010 slt=7; 001000 jr -> jrD=1, regwrite=0; 011010 div -> divD=1, regwrite=0; 010000 mfhi, 010010 mflo -> regwrite=1; other funct -> regwrite=0, illegalD=1.
REQ-016 pcsrcD SHALL equal branchD & (beq ? equalD : ~equalD), combinational.
REQ-017 E register SHALL load the D bundle (incl. divD) each cycle; flushE clears to zero; stallE holds; flushE takes priority over stallE.
REQ-018 M register SHALL load E bundle; flushM clears; stallM holds; if stallE=1 and stallM=0, M loads a bubble (all zero); flushM priority over stallM.
REQ-019 W register SHALL load M bundle every cycle, no stall/flush.
REQ-020 Latency: a D-stage instruction's controls SHALL appear on E outputs 1 cycle later, M 2, W 3, absent stalls.
REQ-021 Divider counter (width clog2(DIV_CYCLES)) SHALL load DIV_CYCLES-1 and set divbusy on the edge where a div enters E with divbusy=0 (i.e., divD=1, flushE=0, stallE=0); held div in E SHALL not reload.
REQ-022 While divbusy=1, counter decrements each cycle; divbusy SHALL drop on the edge after count is 0, giving exactly DIV_CYCLES busy cycles.
REQ-023 divstallD SHALL equal divbusy & (divD | mfhiD | mfloD); divstallD=1 with a div in D SHALL suppress its entry (div does not start while busy).
REQ-024 Divider SHALL run independent of stallE/stallM/flushE/flushM once started.
REQ-025 Flush of an instruction SHALL zero regwrite, memwrite and divD for that slot so no state change leaks.

Reset
REQ-026 rst=1 SHALL asynchronously clear all E/M/W registers (all outputs 0, alucontrolE=0), counter=0, divbusy=0.
REQ-027 rst mid-division SHALL abort it; first div after reset release starts a fresh DIV_CYCLES count.
REQ-028 Decode-stage outputs SHALL stay purely combinational from opD/functD/equalD/divbusy during reset.

Verification
REQ-029 lw (op 100011) in D, no stalls -> cycle+1 alusrcE=1,memtoregE=1,alucontrolE=2; +2 memtoregM=1,regwriteM=1; +3 regwriteW=1,memtoregW=1.
REQ-030 bne with equalD=0 -> pcsrcD=1; beq with equalD=0 -> pcsrcD=0; op 111111 -> illegalD=1, all writes 0.
REQ-031 sw in E with stallE=1,stallM=0 for 2 cycles -> alucontrolE held at 2, memwriteM=0 those cycles, memwriteM=1 cycle after release; flushE=stallE=1 -> E cleared.
REQ-032 div (funct 011010) with DIV_CYCLES=4 -> divbusy high exactly 4 cycles; mflo in D during busy -> divstallD=1; second div in D -> divstallD=1, no counter reload.
REQ-033 rst pulsed mid-division and mid-pipeline (regwriteM=1) -> divbusy=0, regwriteM=0 immediately, before next clk edge.
REQ-034 ALUCTRL_W=5 sub -> alucontrolE=00110.
